s_mem_fill_engine: RTL and testbench

//  Parametrised initialiser for the RC4 S-box RAM (and other scratch RAMs) in the key-search datapath.
//  On start, writes one word per clock over a programmable address window (base, count).

---
 rtl/s_mem_fill_engine.sv | 157 +++++++++++++++
 tb/tb_s_mem_fill_engine.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/s_mem_fill_engine.sv
// s_mem_fill_engine
//   Writes one word per clock into a scratch RAM (e.g. the RC4 S-box) over a
//   window of `count` words starting at `base_addr`. The window wraps modulo
//   DEPTH = 2**ADDR_W. The fill pattern is chosen by `mode`.
//
// Ports
//   clk               system clock, rising edge
//   reset_n           synchronous active-low reset
//   start             launch request, honoured in IDLE or DONE
//   mode              0 identity, 1 constant, 2 descending, 3 relative index
//   fill_value        constant word for mode 1
//   base_addr         first address of the window
//   count             number of words, 0..DEPTH
//   abort             terminates a run, honoured in WRITE
//   address_out       registered RAM address
//   data_out          registered RAM write data
//   write_enable_out  registered RAM write strobe
//   busy              run in progress
//   done              last run finished (held until next launch)
//   aborted           last run ended by abort
//
// state   | meaning
// S_IDLE  | out of reset, nothing launched yet
// S_WRITE | one word issued per cycle
// S_DONE  | run finished or aborted; may be re-launched
module s_mem_fill_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fill_value,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    input  logic              abort,
    output logic [ADDR_W-1:0] address_out,
    output logic [DATA_W-1:0] data_out,
    output logic              write_enable_out,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_DONE} state_t;

    localparam int WIDE = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;

    state_t              state_q;
    logic [1:0]          mode_q;
    logic [DATA_W-1:0]   fill_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     count_q;
    logic [ADDR_W:0]     idx_q;      // index of the next word to issue
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                we_q;
    logic                done_q;
    logic                aborted_q;

    logic                launch;
    logic [1:0]          wr_mode;
    logic [DATA_W-1:0]   wr_fill;
    logic [ADDR_W-1:0]   wr_addr;
    logic [ADDR_W-1:0]   wr_addr_inv;
    logic [ADDR_W-1:0]   wr_j;
    logic [WIDE-1:0]     wide_v;
    logic [DATA_W-1:0]   data_d;

    // The first word is produced straight from the inputs on the launch edge,
    // later words from the latched run parameters.
    always_comb begin
        launch      = (state_q != S_WRITE) && start;
        wr_mode     = launch ? mode : mode_q;
        wr_fill     = launch ? fill_value : fill_q;
        wr_addr     = launch ? base_addr : (base_q + idx_q[ADDR_W-1:0]);
        wr_j        = launch ? '0 : idx_q[ADDR_W-1:0];
        wr_addr_inv = ~wr_addr;
        wide_v      = '0;
        case (wr_mode)
            2'd0:    wide_v[ADDR_W-1:0] = wr_addr;
            2'd2:    wide_v[ADDR_W-1:0] = wr_addr_inv;
            2'd3:    wide_v[ADDR_W-1:0] = wr_j;
            default: wide_v = '0;
        endcase
        data_d = wide_v[DATA_W-1:0];
        if (wr_mode == 2'd1) data_d = wr_fill;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            fill_q    <= '0;
            base_q    <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        if (count != '0) begin
                            state_q   <= S_WRITE;
                            mode_q    <= mode;
                            fill_q    <= fill_value;
                            base_q    <= base_addr;
                            count_q   <= count;
                            idx_q     <= (ADDR_W+1)'(1);
                            addr_q    <= wr_addr;
                            data_q    <= data_d;
                            we_q      <= 1'b1;
                            done_q    <= 1'b0;
                            aborted_q <= 1'b0;
                        end else begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            aborted_q <= 1'b0;
                        end
                    end
                end
                S_WRITE: begin
                    if (abort) begin
                        // abort wins even when the final word is on the bus
                        state_q   <= S_DONE;
                        we_q      <= 1'b0;
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                    end else if (idx_q == count_q) begin
                        state_q   <= S_DONE;
                        we_q      <= 1'b0;
                        done_q    <= 1'b1;
                        aborted_q <= 1'b0;
                    end else begin
                        addr_q    <= wr_addr;
                        data_q    <= data_d;
                        idx_q     <= idx_q + (ADDR_W+1)'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign address_out      = addr_q;
    assign data_out         = data_q;
    assign write_enable_out = we_q;
    assign busy             = (state_q == S_WRITE);
    assign done             = done_q;
    assign aborted          = aborted_q;

endmodule

// File: tb/tb_s_mem_fill_engine.sv
module tb_s_mem_fill_engine;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [1:0] mode;
    logic [7:0] fill_value;
    logic [7:0] base_addr;
    logic [8:0] count;
    logic       abort;
    logic [7:0] address_out;
    logic [7:0] data_out;
    logic       write_enable_out;
    logic       busy;
    logic       done;
    logic       aborted;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int n;
    int bad;
    logic [7:0] ram [256];

    s_mem_fill_engine #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .mode             (mode),
        .fill_value       (fill_value),
        .base_addr        (base_addr),
        .count            (count),
        .abort            (abort),
        .address_out      (address_out),
        .data_out         (data_out),
        .write_enable_out (write_enable_out),
        .busy             (busy),
        .done             (done),
        .aborted          (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: captures whatever the engine strobes at each rising edge
    always @(posedge clk) begin
        if (write_enable_out === 1'b1) begin
            ram[address_out] = data_out;
            wr_cnt = wr_cnt + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_ram();
        for (int i = 0; i < 256; i++) ram[i] = 8'h33;
        wr_cnt = 0;
    endtask

    task automatic launch(input logic [1:0] m, input logic [7:0] f,
                          input logic [7:0] b, input logic [8:0] c);
        mode = m; fill_value = f; base_addr = b; count = c; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic run_to_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 400) begin
            step();
            cycles++;
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; mode = 2'd0; fill_value = 8'h00;
        base_addr = 8'h00; count = 9'd0; abort = 1'b0;
        step(); step();
        check("reset_outputs", {address_out, data_out, write_enable_out, busy, done, aborted}, 32'h0);
        reset_n = 1'b1;
        step();
        check("idle_outputs", {write_enable_out, busy, done, aborted}, 32'h0);

        // T1 identity over the whole RAM
        fill_ram();
        launch(2'd0, 8'h00, 8'h00, 9'd256);
        check("t1_first_we", write_enable_out, 1'b1);
        check("t1_first_busy", busy, 1'b1);
        check("t1_first_addr", address_out, 8'h00);
        run_to_done(n);
        check("t1_cycles_to_done", n, 256);
        check("t1_writes", wr_cnt, 256);
        bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== 8'(i)) bad++;
        check("t1_ram_bad", bad, 0);
        check("t1_end_flags", {write_enable_out, busy, done, aborted}, 32'b0010);
        check("t1_addr_hold", {address_out, data_out}, 32'hFFFF);

        // T2 constant fill over a wrapping partial window, launched from DONE
        fill_ram();
        launch(2'd1, 8'hA5, 8'hF0, 9'd32);
        check("t2_launch_flags", {write_enable_out, busy, done, aborted}, 32'b1100);
        check("t2_first_word", {address_out, data_out}, 32'hF0A5);
        run_to_done(n);
        check("t2_cycles_to_done", n, 32);
        check("t2_writes", wr_cnt, 32);
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (ram[i] !== ((i >= 8'hF0 || i < 8'h10) ? 8'hA5 : 8'h33)) bad++;
        check("t2_ram_bad", bad, 0);
        check("t2_last_addr", address_out, 8'h0F);

        // T3 zero-length launch
        fill_ram();
        launch(2'd0, 8'h00, 8'h40, 9'd0);
        check("t3_flags", {write_enable_out, busy, done, aborted}, 32'b0010);
        step(); step();
        check("t3_writes", wr_cnt, 0);

        // T4 abort on the tenth write cycle
        fill_ram();
        launch(2'd0, 8'h00, 8'h00, 9'd256);
        for (int i = 0; i < 9; i++) step();
        check("t4_tenth_addr", {write_enable_out, address_out}, 32'h109);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_flags", {write_enable_out, busy, done, aborted}, 32'b0011);
        check("t4_writes", wr_cnt, 10);
        check("t4_ram_edges", {ram[9], ram[10]}, 32'h0933);
        check("t4_addr_hold", address_out, 8'h09);

        // T5 descending relaunch from an aborted DONE
        fill_ram();
        launch(2'd2, 8'h00, 8'h00, 9'd256);
        check("t5_launch_flags", {done, aborted}, 32'b00);
        check("t5_first_word", {address_out, data_out}, 32'h00FF);
        run_to_done(n);
        check("t5_cycles_to_done", n, 256);
        bad = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== 8'(255 - i)) bad++;
        check("t5_ram_bad", bad, 0);

        // T6 reset in the middle of a relative-index run
        fill_ram();
        launch(2'd3, 8'h00, 8'h10, 9'd256);
        for (int i = 0; i < 99; i++) step();
        check("t6_write100", {write_enable_out, address_out, data_out}, 32'h17363);
        reset_n = 1'b0;
        step();
        check("t6_reset_outputs", {address_out, data_out, write_enable_out, busy, done, aborted}, 32'h0);
        reset_n = 1'b1;
        step();
        check("t6_idle_outputs", {write_enable_out, busy, done, aborted}, 32'h0);

        // fresh run after reset: relative index across the wrap point
        fill_ram();
        launch(2'd3, 8'h00, 8'hFE, 9'd4);
        check("t6b_w0", {write_enable_out, address_out, data_out}, 32'h1FE00);
        step();
        check("t6b_w1", {write_enable_out, address_out, data_out}, 32'h1FF01);
        step();
        check("t6b_w2", {write_enable_out, address_out, data_out}, 32'h10002);
        step();
        check("t6b_w3", {write_enable_out, address_out, data_out}, 32'h10103);
        step();
        check("t6b_end_flags", {write_enable_out, busy, done, aborted}, 32'b0010);
        check("t6b_writes", wr_cnt, 4);

        // abort is ignored outside WRITE and start is ignored inside WRITE
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_in_done", {done, aborted}, 32'b10);
        fill_ram();
        launch(2'd1, 8'h5A, 8'h20, 9'd3);
        mode = 2'd0; base_addr = 8'h80; count = 9'd1; start = 1'b1;
        step();
        start = 1'b0;
        check("start_in_write", {busy, address_out, data_out}, 32'h1215A);
        run_to_done(n);
        check("start_in_write_writes", wr_cnt, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
